// File: rtl/benes_route_sequencer_pkg.sv
// Shared types for the Benes route sequencer: switch-configuration word and channel FSM states.
package benes_route_sequencer_pkg;

  localparam int unsigned STAGE_NUM  = 7;
  localparam int unsigned SWITCH_NUM = 8;

  typedef logic [STAGE_NUM-1:0][SWITCH_NUM-1:0] benes_cfg_t;

  typedef enum logic [2:0] {
    StIdle,
    StArb,
    StLoad,
    StStream,
    StDrain
  } chan_state_e;

endpackage

// File: rtl/benes_route_sequencer_chan_ctrl.sv
// Per-direction transfer controller: FSM, beat counter, write-enable delay line and select register.
// Optional performance counters are built only when BENES_SEQ_PERF_EN is defined.
module benes_chan_ctrl
  import benes_route_sequencer_pkg::*;
#(
  parameter int unsigned RidW    = 4,
  parameter int unsigned LenW    = 8,
  parameter int unsigned PipeLat = 7
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [RidW-1:0] route_id_i,
  input  logic [LenW-1:0] len_i,
  output logic [RidW-1:0] route_id_o,
  output logic            arb_req_o,
  input  logic            arb_gnt_i,
  input  benes_cfg_t      cfg_i,
  output logic            src_rd_o,
  output logic            dst_wren_o,
  output logic            done_o,
  output benes_cfg_t      sel_o,
  output logic [31:0]     perf_beats_o,
  output logic [31:0]     perf_stall_o
);

  // Pattern of the delay line when the final beat is leaving it.
  localparam logic [PipeLat-1:0] WrenLast = PipeLat'(1) << (PipeLat - 1);

  chan_state_e        state_q;
  logic               ready_q;
  logic               src_rd_q;
  logic               done_q;
  logic [RidW-1:0]    rid_q;
  logic [LenW-1:0]    cnt_q;
  benes_cfg_t         sel_q;
  logic [PipeLat-1:0] wren_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      ready_q  <= 1'b1;
      src_rd_q <= 1'b0;
      done_q   <= 1'b0;
      rid_q    <= '0;
      cnt_q    <= '0;
      sel_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid_i && ready_q) begin
            rid_q   <= route_id_i;
            cnt_q   <= len_i;
            ready_q <= 1'b0;
            state_q <= StArb;
          end
        end
        StArb: begin
          if (arb_gnt_i) state_q <= StLoad;
        end
        StLoad: begin
          sel_q <= cfg_i;
          if (cnt_q == '0) begin
            done_q  <= 1'b1;
            state_q <= StDrain;
          end else begin
            src_rd_q <= 1'b1;
            state_q  <= StStream;
          end
        end
        StStream: begin
          cnt_q <= cnt_q - LenW'(1);
          if (cnt_q == LenW'(1)) begin
            src_rd_q <= 1'b0;
            state_q  <= StDrain;
          end
        end
        StDrain: begin
          // Done is raised while still in DRAIN so the next accept follows it.
          if (done_q) begin
            ready_q <= 1'b1;
            state_q <= StIdle;
          end else if (wren_q == WrenLast) begin
            done_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wren_q <= '0;
    end else begin
      wren_q <= (wren_q << 1) | PipeLat'(src_rd_q);
    end
  end

  assign req_ready_o = ready_q;
  assign route_id_o  = rid_q;
  assign arb_req_o   = (state_q == StArb);
  assign src_rd_o    = src_rd_q;
  assign dst_wren_o  = wren_q[PipeLat-1];
  assign done_o      = done_q;
  assign sel_o       = sel_q;

`ifdef BENES_SEQ_PERF_EN
  logic [31:0] beats_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      beats_q <= '0;
      stall_q <= '0;
    end else begin
      if (wren_q[PipeLat-1]) beats_q <= beats_q + 32'd1;
      if ((state_q == StArb) && !arb_gnt_i) stall_q <= stall_q + 32'd1;
    end
  end

  assign perf_beats_o = beats_q;
  assign perf_stall_o = stall_q;
`else
  assign perf_beats_o = '0;
  assign perf_stall_o = '0;
`endif

endmodule

// File: rtl/benes_route_sequencer.sv
// Sequences the R2M and M2R Benes networks from a shared switch-configuration table.
// Define BENES_SEQ_PERF_EN to build the per-channel beat/stall counters.
module benes_route_sequencer
  import benes_route_sequencer_pkg::*;
#(
  parameter int unsigned ROUTE_NUM = 16,
  parameter int unsigned LEN_W     = 8,
  parameter int unsigned PIPE_LAT  = 7,
  localparam int unsigned RID_W    = $clog2(ROUTE_NUM)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_cfg_wr_en,
  input  logic [RID_W-1:0] i_cfg_wr_addr,
  input  benes_cfg_t       i_cfg_wr_data,
  input  logic             i_r2m_req_valid,
  output logic             o_r2m_req_ready,
  input  logic [RID_W-1:0] i_r2m_route_id,
  input  logic [LEN_W-1:0] i_r2m_len,
  output logic             o_r2m_src_rd,
  output logic             o_r2m_dst_wren,
  output logic             o_r2m_done,
  input  logic             i_m2r_req_valid,
  output logic             o_m2r_req_ready,
  input  logic [RID_W-1:0] i_m2r_route_id,
  input  logic [LEN_W-1:0] i_m2r_len,
  output logic             o_m2r_src_rd,
  output logic             o_m2r_dst_wren,
  output logic             o_m2r_done,
  output benes_cfg_t       o_module_select,
  output benes_cfg_t       o_slot_select,
  output logic [31:0]      o_r2m_perf_beats,
  output logic [31:0]      o_r2m_perf_stall,
  output logic [31:0]      o_m2r_perf_beats,
  output logic [31:0]      o_m2r_perf_stall
);

  benes_cfg_t       cfg_mem [ROUTE_NUM];
  benes_cfg_t       rd_data_q;
  logic             rr_q;  // 0: r2m wins a tie, 1: m2r wins a tie
  logic             r2m_arb_req, m2r_arb_req;
  logic             r2m_gnt, m2r_gnt;
  logic [RID_W-1:0] r2m_rid, m2r_rid;
  logic [RID_W-1:0] rd_addr;

  always_comb begin
    r2m_gnt = r2m_arb_req && (!m2r_arb_req || !rr_q);
    m2r_gnt = m2r_arb_req && (!r2m_arb_req || rr_q);
    rd_addr = r2m_gnt ? r2m_rid : m2r_rid;
  end

  // Table is deliberately not reset; a read colliding with a write sees the old entry.
  always_ff @(posedge clk) begin
    if (i_cfg_wr_en) cfg_mem[i_cfg_wr_addr] <= i_cfg_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q      <= 1'b0;
      rd_data_q <= '0;
    end else begin
      if (r2m_gnt || m2r_gnt) rd_data_q <= cfg_mem[rd_addr];
      if (r2m_gnt) begin
        rr_q <= 1'b1;
      end else if (m2r_gnt) begin
        rr_q <= 1'b0;
      end
    end
  end

  benes_chan_ctrl #(
    .RidW   (RID_W),
    .LenW   (LEN_W),
    .PipeLat(PIPE_LAT)
  ) u_r2m (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (i_r2m_req_valid),
    .req_ready_o (o_r2m_req_ready),
    .route_id_i  (i_r2m_route_id),
    .len_i       (i_r2m_len),
    .route_id_o  (r2m_rid),
    .arb_req_o   (r2m_arb_req),
    .arb_gnt_i   (r2m_gnt),
    .cfg_i       (rd_data_q),
    .src_rd_o    (o_r2m_src_rd),
    .dst_wren_o  (o_r2m_dst_wren),
    .done_o      (o_r2m_done),
    .sel_o       (o_module_select),
    .perf_beats_o(o_r2m_perf_beats),
    .perf_stall_o(o_r2m_perf_stall)
  );

  benes_chan_ctrl #(
    .RidW   (RID_W),
    .LenW   (LEN_W),
    .PipeLat(PIPE_LAT)
  ) u_m2r (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (i_m2r_req_valid),
    .req_ready_o (o_m2r_req_ready),
    .route_id_i  (i_m2r_route_id),
    .len_i       (i_m2r_len),
    .route_id_o  (m2r_rid),
    .arb_req_o   (m2r_arb_req),
    .arb_gnt_i   (m2r_gnt),
    .cfg_i       (rd_data_q),
    .src_rd_o    (o_m2r_src_rd),
    .dst_wren_o  (o_m2r_dst_wren),
    .done_o      (o_m2r_done),
    .sel_o       (o_slot_select),
    .perf_beats_o(o_m2r_perf_beats),
    .perf_stall_o(o_m2r_perf_stall)
  );

endmodule

// File: tb/tb_benes_route_sequencer.sv
// Scoreboard bench for benes_route_sequencer: strobe events are predicted per request and
// compared against the events observed on the channel outputs.
`timescale 1ns/1ps
module tb_benes_route_sequencer;
  import benes_route_sequencer_pkg::*;

  localparam int PL = 7;
`ifdef BENES_SEQ_PERF_EN
  localparam int PERF = 1;
`else
  localparam int PERF = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_cfg_wr_en = 1'b0;
  logic [3:0]  i_cfg_wr_addr = '0;
  benes_cfg_t  i_cfg_wr_data = '0;
  logic        i_r2m_req_valid = 1'b0, i_m2r_req_valid = 1'b0;
  logic [3:0]  i_r2m_route_id = '0, i_m2r_route_id = '0;
  logic [7:0]  i_r2m_len = '0, i_m2r_len = '0;
  logic        o_r2m_req_ready, o_r2m_src_rd, o_r2m_dst_wren, o_r2m_done;
  logic        o_m2r_req_ready, o_m2r_src_rd, o_m2r_dst_wren, o_m2r_done;
  benes_cfg_t  o_module_select, o_slot_select;
  logic [31:0] o_r2m_perf_beats, o_r2m_perf_stall, o_m2r_perf_beats, o_m2r_perf_stall;

  benes_route_sequencer #(
    .ROUTE_NUM(16),
    .LEN_W    (8),
    .PIPE_LAT (PL)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_cfg_wr_en     (i_cfg_wr_en),
    .i_cfg_wr_addr   (i_cfg_wr_addr),
    .i_cfg_wr_data   (i_cfg_wr_data),
    .i_r2m_req_valid (i_r2m_req_valid),
    .o_r2m_req_ready (o_r2m_req_ready),
    .i_r2m_route_id  (i_r2m_route_id),
    .i_r2m_len       (i_r2m_len),
    .o_r2m_src_rd    (o_r2m_src_rd),
    .o_r2m_dst_wren  (o_r2m_dst_wren),
    .o_r2m_done      (o_r2m_done),
    .i_m2r_req_valid (i_m2r_req_valid),
    .o_m2r_req_ready (o_m2r_req_ready),
    .i_m2r_route_id  (i_m2r_route_id),
    .i_m2r_len       (i_m2r_len),
    .o_m2r_src_rd    (o_m2r_src_rd),
    .o_m2r_dst_wren  (o_m2r_dst_wren),
    .o_m2r_done      (o_m2r_done),
    .o_module_select (o_module_select),
    .o_slot_select   (o_slot_select),
    .o_r2m_perf_beats(o_r2m_perf_beats),
    .o_r2m_perf_stall(o_r2m_perf_stall),
    .o_m2r_perf_beats(o_m2r_perf_beats),
    .o_m2r_perf_stall(o_m2r_perf_stall)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  int obs_q[$];
  int exp_q[$];
  benes_cfg_t tbl [16];
  benes_cfg_t exp_msel = '0;
  benes_cfg_t exp_ssel = '0;

  // Event key: cycle, channel (0 r2m, 1 m2r), kind (0 src_rd, 1 dst_wren, 2 done).
  function automatic int key(input int c, input int ch, input int kind);
    return c * 8 + ch * 4 + kind;
  endfunction

  always @(negedge clk) begin
    if (o_r2m_src_rd)   obs_q.push_back(key(cyc, 0, 0));
    if (o_r2m_dst_wren) obs_q.push_back(key(cyc, 0, 1));
    if (o_r2m_done)     obs_q.push_back(key(cyc, 0, 2));
    if (o_m2r_src_rd)   obs_q.push_back(key(cyc, 1, 0));
    if (o_m2r_dst_wren) obs_q.push_back(key(cyc, 1, 1));
    if (o_m2r_done)     obs_q.push_back(key(cyc, 1, 2));
  end

  // Reference timing for a request presented in cycle t and granted without stall.
  function automatic void sb_push(input int ch, input int t, input int len);
    if (len == 0) begin
      exp_q.push_back(key(t + 3, ch, 2));
      return;
    end
    for (int c = t + 3; c <= t + 3 + len + PL; c++) begin
      if (c <= t + 2 + len) exp_q.push_back(key(c, ch, 0));
      if (c >= t + 3 + PL && c <= t + 2 + len + PL) exp_q.push_back(key(c, ch, 1));
      if (c == t + 3 + len + PL) exp_q.push_back(key(c, ch, 2));
    end
  endfunction

  function automatic benes_cfg_t mk_cfg(input int i, input int salt);
    benes_cfg_t v;
    for (int k = 0; k < STAGE_NUM; k++) v[k] = SWITCH_NUM'((i * 29 + k * 7 + salt * 13 + 1) & 255);
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_table(input int salt);
    for (int i = 0; i < 16; i++) begin
      tbl[i]        = mk_cfg(i, salt);
      i_cfg_wr_en   = 1'b1;
      i_cfg_wr_addr = 4'(i);
      i_cfg_wr_data = tbl[i];
      tick(1);
    end
    i_cfg_wr_en = 1'b0;
  endtask

  task automatic present(input logic rv, input int rid, input int rlen, input logic mv,
                         input int mid, input int mlen, output int t);
    i_r2m_req_valid = rv; i_r2m_route_id = 4'(rid); i_r2m_len = 8'(rlen);
    i_m2r_req_valid = mv; i_m2r_route_id = 4'(mid); i_m2r_len = 8'(mlen);
    t = cyc;
    tick(1);
    i_r2m_req_valid = 1'b0;
    i_m2r_req_valid = 1'b0;
  endtask

  task automatic do_reset(input int salt);
    rst_n = 1'b0;
    tick(3);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    exp_msel = '0;
    exp_ssel = '0;
    load_table(salt);
  endtask

  task automatic test_reset;
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      checks++;
      if ({o_r2m_req_ready, o_m2r_req_ready} !== 2'b11) begin
        errors++; $display("FAIL reset_ready[%0d]: got %b, expected 11", pass,
                           {o_r2m_req_ready, o_m2r_req_ready});
      end
      checks++;
      if ({o_r2m_src_rd, o_r2m_dst_wren, o_r2m_done, o_m2r_src_rd, o_m2r_dst_wren, o_m2r_done}
          !== 6'b0) begin
        errors++; $display("FAIL reset_strobes[%0d]: got %b, expected 000000", pass,
          {o_r2m_src_rd, o_r2m_dst_wren, o_r2m_done, o_m2r_src_rd, o_m2r_dst_wren, o_m2r_done});
      end
      checks++;
      if ({o_module_select, o_slot_select} !== '0) begin
        errors++; $display("FAIL reset_selects[%0d]: got %h/%h, expected 0", pass,
                           o_module_select, o_slot_select);
      end
      checks++;
      if ({o_r2m_perf_beats, o_r2m_perf_stall, o_m2r_perf_beats, o_m2r_perf_stall} !== '0) begin
        errors++; $display("FAIL reset_perf[%0d]: counters nonzero", pass);
      end
      if (pass == 0) begin
        rst_n = 1'b1;
        tick(1);
      end
    end
  endtask

  task automatic test_single;
    int t;
    benes_cfg_t e;
    obs_q.delete(); exp_q.delete();
    present(1'b1, 3, 4, 1'b0, 0, 0, t);
    sb_push(0, t, 4);
    for (int c = t + 1; c <= t + 16; c++) begin
      @(negedge clk);
      e = (c >= t + 3) ? tbl[3] : exp_msel;
      checks++;
      if (o_module_select !== e) begin
        errors++; $display("FAIL single_msel@%0d: got %h, expected %h", c - t, o_module_select, e);
      end
      tick(1);
    end
    exp_msel = tbl[3];
    exp_q.sort();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL single_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL single_event[%0d]: got key %0d, expected key %0d", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_arb;
    int t;
    benes_cfg_t em, es;
    do_reset(1);
    obs_q.delete(); exp_q.delete();
    present(1'b1, 2, 3, 1'b1, 9, 2, t);
    sb_push(0, t, 3);
    sb_push(1, t + 1, 2);
    for (int c = t + 1; c <= t + 15; c++) begin
      @(negedge clk);
      em = (c >= t + 3) ? tbl[2] : exp_msel;
      es = (c >= t + 4) ? tbl[9] : exp_ssel;
      checks++;
      if ({o_module_select, o_slot_select} !== {em, es}) begin
        errors++; $display("FAIL arb_sel@%0d: got %h/%h, expected %h/%h", c - t,
                           o_module_select, o_slot_select, em, es);
      end
      tick(1);
    end
    exp_msel = tbl[2];
    exp_ssel = tbl[9];
    checks++;
    if (o_m2r_perf_stall !== 32'(PERF)) begin
      errors++; $display("FAIL arb_m2r_stall: got %0d, expected %0d", o_m2r_perf_stall, PERF);
    end
    checks++;
    if (o_r2m_perf_stall !== 32'd0) begin
      errors++; $display("FAIL arb_r2m_stall: got %0d, expected 0", o_r2m_perf_stall);
    end
    exp_q.sort();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL arb_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL arb_event[%0d]: got key %0d, expected key %0d", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_len0;
    int t;
    benes_cfg_t es;
    obs_q.delete(); exp_q.delete();
    present(1'b0, 0, 0, 1'b1, 7, 0, t);
    sb_push(1, t, 0);
    for (int c = t + 1; c <= t + 6; c++) begin
      @(negedge clk);
      es = (c >= t + 3) ? tbl[7] : exp_ssel;
      checks++;
      if ({o_module_select, o_slot_select} !== {exp_msel, es}) begin
        errors++; $display("FAIL len0_sel@%0d: got %h/%h, expected %h/%h", c - t,
                           o_module_select, o_slot_select, exp_msel, es);
      end
      if (c == t + 4) begin
        checks++;
        if (o_m2r_req_ready !== 1'b1) begin
          errors++; $display("FAIL len0_ready: got %b, expected 1", o_m2r_req_ready);
        end
      end
      tick(1);
    end
    exp_ssel = tbl[7];
    exp_q.sort();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL len0_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL len0_event[%0d]: got key %0d, expected key %0d", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_cfg_collision;
    int t, t2;
    benes_cfg_t old5, new5, e;
    obs_q.delete(); exp_q.delete();
    old5 = tbl[5];
    new5 = mk_cfg(5, 99);
    i_r2m_req_valid = 1'b1; i_r2m_route_id = 4'd5; i_r2m_len = 8'd1;
    t = cyc;
    tick(1);
    // Write lands on the same edge as the granted table read.
    i_r2m_req_valid = 1'b0;
    i_cfg_wr_en = 1'b1; i_cfg_wr_addr = 4'd5; i_cfg_wr_data = new5;
    tick(1);
    i_cfg_wr_en = 1'b0;
    tbl[5] = new5;
    sb_push(0, t, 1);
    for (int c = t + 2; c <= t + 13; c++) begin
      @(negedge clk);
      e = (c >= t + 3) ? old5 : exp_msel;
      checks++;
      if (o_module_select !== e) begin
        errors++; $display("FAIL coll_old@%0d: got %h, expected %h", c - t, o_module_select, e);
      end
      tick(1);
    end
    present(1'b1, 5, 1, 1'b0, 0, 0, t2);
    sb_push(0, t2, 1);
    for (int c = t2 + 1; c <= t2 + 12; c++) begin
      @(negedge clk);
      e = (c >= t2 + 3) ? new5 : old5;
      checks++;
      if (o_module_select !== e) begin
        errors++; $display("FAIL coll_new@%0d: got %h, expected %h", c - t2, o_module_select, e);
      end
      tick(1);
    end
    exp_msel = new5;
    exp_q.sort();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL coll_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL coll_event[%0d]: got key %0d, expected key %0d", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int t;
    present(1'b1, 4, 8, 1'b0, 0, 0, t);
    tick(4);
    @(negedge clk);
    checks++;
    if (o_r2m_src_rd !== 1'b1) begin
      errors++; $display("FAIL mid_streaming: got src_rd=%b, expected 1", o_r2m_src_rd);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_r2m_src_rd, o_r2m_dst_wren, o_r2m_done} !== 3'b000) begin
      errors++; $display("FAIL mid_strobes: got %b, expected 000",
                         {o_r2m_src_rd, o_r2m_dst_wren, o_r2m_done});
    end
    checks++;
    if (o_module_select !== '0 || o_r2m_req_ready !== 1'b1) begin
      errors++; $display("FAIL mid_state: got sel=%h ready=%b, expected sel=0 ready=1",
                         o_module_select, o_r2m_req_ready);
    end
    obs_q.delete();
    tick(3);
    @(negedge clk);
    rst_n = 1'b1;
    tick(20);
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL mid_no_events: got %0d events after reset, expected 0", obs_q.size());
    end
    checks++;
    if (o_r2m_req_ready !== 1'b1) begin
      errors++; $display("FAIL mid_ready: got %b, expected 1", o_r2m_req_ready);
    end
    exp_msel = '0;
    exp_ssel = '0;
    load_table(2);
  endtask

  task automatic test_back_to_back;
    int t;
    obs_q.delete(); exp_q.delete();
    i_r2m_req_valid = 1'b1; i_r2m_route_id = 4'd1; i_r2m_len = 8'd3;
    t = cyc;
    tick(1);
    i_r2m_route_id = 4'd2; i_r2m_len = 8'd2;
    sb_push(0, t, 3);
    sb_push(0, t + 14, 2);
    for (int c = t + 1; c <= t + 30; c++) begin
      @(negedge clk);
      if (c == t + 13 || c == t + 14) begin
        checks++;
        if (o_r2m_req_ready !== (c == t + 14)) begin
          errors++; $display("FAIL b2b_ready@%0d: got %b, expected %b", c - t, o_r2m_req_ready,
                             (c == t + 14));
        end
      end
      tick(1);
      if (c == t + 14) i_r2m_req_valid = 1'b0;
    end
    checks++;
    if (o_r2m_perf_beats !== 32'(PERF * 5) || o_m2r_perf_beats !== 32'd0) begin
      errors++; $display("FAIL b2b_perf: got %0d/%0d, expected %0d/0", o_r2m_perf_beats,
                         o_m2r_perf_beats, PERF * 5);
    end
    checks++;
    if (o_module_select !== tbl[2]) begin
      errors++; $display("FAIL b2b_sel: got %h, expected %h", o_module_select, tbl[2]);
    end
    exp_q.sort();
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL b2b_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_event[%0d]: got key %0d, expected key %0d", i, obs_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    tick(2);
    test_reset;
    load_table(0);
    test_single;
    test_arb;
    test_len0;
    test_cfg_collision;
    test_reset_mid;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
